vga_sprite_renderer: RTL
========================

# vga_sprite_renderer

Parametrised 640x480-class VGA timing generator and multi-sprite renderer for the frog game display path. Generates hsync/vsync, reads NUM_SPRITES independently positioned SPRITE_SIZE-square sprites from internal writable pattern RAM, and resolves them against an optional grid overlay. Output RGB is fully registered and aligned with the syncs. Sprite positions are double-buffered so game-logic updates never tear mid-frame.

## Interface
- H_DISPLAY, 640: active pixels per line
- H_FRONT, 16 / H_SYNC, 96 / H_BACK, 48: horizontal porch and sync widths
- V_DISPLAY, 480: active lines
- V_FRONT, 10 / V_SYNC, 2 / V_BACK, 33: vertical porch and sync widths
- NUM_SPRITES, 4: sprite channels (1..8)
- SPRITE_SIZE, 32: sprite edge in pixels (power of 2)
- BPP, 2: bits per sprite pixel (1..3)
- GRID_SIZE, 32: grid pitch (power of 2)
- GRID_EN, 1: 1 = draw white grid lines

- clk  in  1  pixel clock
- rst  in  1  synchronous reset, active-high
- sprite_x  in  10*NUM_SPRITES  X of sprite s at [s*10 +: 10]
- sprite_y  in  10*NUM_SPRITES  Y of sprite s at [s*10 +: 10]
- sprite_en  in  NUM_SPRITES  per-sprite enable
- wr_en  in  1  pattern RAM write strobe
- wr_sel  in  clog2(NUM_SPRITES)  sprite to write
- wr_row  in  clog2(SPRITE_SIZE)  row to write
- wr_data  in  SPRITE_SIZE*BPP  row data; column c at [c*BPP +: BPP]
- pal_wr  in  1  palette write strobe
- pal_idx  in  BPP  palette entry
- pal_data  in  9  {r[2:0], g[2:0], b[2:0]}
- red, green, blue  out  3 each  VGA colour
- hsync, vsync  out  1 each  active-high sync
- vblank_start  out  1  one-cycle pulse when positions latch

## Operation
- Counters h (0..H_TOTAL-1), v (0..V_TOTAL-1); h wraps to 0 and v increments at h=H_TOTAL-1; v wraps at V_TOTAL-1.
- Shadow registers: sprite_x/y/en sampled into shadow copies only on the cycle h=0, v=V_DISPLAY; rendering uses shadows exclusively. vblank_start asserted the following cycle.
- Hit for sprite s: en_s && h >= x_s && h < x_s+SPRITE_SIZE (and same for v), computed at 11 bits, no wrap-around. Sprites crossing right/bottom edges are clipped; nothing appears at the left/top.
- Pixel index = row (v - y_s) bits at column (h - x_s). Index 0 = transparent.
- Priority: lowest-numbered sprite with non-transparent pixel wins.
- Compose per active pixel: winning sprite colour via palette; else white (9'h1FF) if GRID_EN and (h%GRID_SIZE==0 or v%GRID_SIZE==0); else black. Grid sits under sprites.
- Blanking (h >= H_DISPLAY or v >= V_DISPLAY): RGB = 0.
- hsync = h in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC); vsync likewise on v.
- Pattern RAM: NUM_SPRITES x SPRITE_SIZE rows, synchronous write on wr_en; out-of-range wr_sel ignored. Writes allowed at any time.
- Palette: 2^BPP entries; entry 0 writes stored but never displayed. Reset values (BPP=2): 1 = 9'h1C7 (pink), 2 = 9'h1FF (white), 3 = 9'h038 (green); others 0.

## Timing
- Pipeline: stage 0 counters -> stage 1 registered hit flags, column offsets, RAM row reads -> stage 2 registered priority/palette/grid result.
- red/green/blue, hsync, vsync all appear exactly 2 cycles after the counter value that produced them; syncs delayed through matching registers.
- RAM read-during-write same row: old data returned; new data visible on next read.
- Palette write takes effect for pixels reaching stage 2 on the next cycle.
- Reset: h=v=0, shadow enables 0, pipeline cleared; RGB=0, hsync=0, vsync=0, vblank_start=0 from the cycle after rst sampled high. Pattern RAM contents not cleared; palette restored to reset values. Reset mid-frame restarts at (0,0).

## Test plan
- Reset then free-run: hsync high 96 cycles per 800-cycle line starting at output cycle 656+2; vsync high lines 490-491 of 525; vblank_start once per frame.
- Sprite 0 row 0 = all index 1, en, x=64,y=0 after latch: output pixels (64..95, 0) = 9'h1C7, pixel 63 and 96 = grid/black.
- Sprites 0 and 1 both at (100,100), sprite 0 pixel index 0 at column 0, sprite 1 index 2: pixel (100,100) white from sprite 1; elsewhere sprite 0 colour.
- Change sprite_x from 64 to 200 at line 240: rest of frame still drawn at 64; next frame at 200.
- x=630, 32-wide sprite: columns 630..639 drawn, nothing at columns 0..21 of same or next line; x=1000 never visible.
- pal_wr idx 1 = 9'h007 mid-line: sprite pixels turn blue from next stage-2 cycle; rst high restores 9'h1C7.

Source files
------------

// File: rtl/vga_sprite_renderer.sv
// VGA timing generator with NUM_SPRITES double-buffered sprites over an optional grid.
// Three-stage pipeline: counters -> hit/RAM row read -> priority/palette/grid; syncs delayed to match.
module vga_sprite_renderer #(
  parameter int unsigned H_DISPLAY   = 640,
  parameter int unsigned H_FRONT     = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BACK      = 48,
  parameter int unsigned V_DISPLAY   = 480,
  parameter int unsigned V_FRONT     = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BACK      = 33,
  parameter int unsigned NUM_SPRITES = 4,
  parameter int unsigned SPRITE_SIZE = 32,
  parameter int unsigned BPP         = 2,
  parameter int unsigned GRID_SIZE   = 32,
  parameter int unsigned GRID_EN     = 1,
  localparam int unsigned SELW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1,
  localparam int unsigned CW   = (SPRITE_SIZE > 1) ? $clog2(SPRITE_SIZE) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [10*NUM_SPRITES-1:0]   sprite_x,
  input  logic [10*NUM_SPRITES-1:0]   sprite_y,
  input  logic [NUM_SPRITES-1:0]      sprite_en,
  input  logic                        wr_en,
  input  logic [SELW-1:0]             wr_sel,
  input  logic [CW-1:0]               wr_row,
  input  logic [SPRITE_SIZE*BPP-1:0]  wr_data,
  input  logic                        pal_wr,
  input  logic [BPP-1:0]              pal_idx,
  input  logic [8:0]                  pal_data,
  output logic [2:0]                  red,
  output logic [2:0]                  green,
  output logic [2:0]                  blue,
  output logic                        hsync,
  output logic                        vsync,
  output logic                        vblank_start
);
  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned ROWW    = SPRITE_SIZE * BPP;
  localparam int unsigned NPAL    = 2 ** BPP;
  localparam logic [10:0] GMASK   = 11'(GRID_SIZE - 1);

  function automatic logic [8:0] pal_init(input int unsigned i);
    case (i)
      1:       return 9'h1C7;
      2:       return 9'h1FF;
      3:       return 9'h038;
      default: return 9'h000;
    endcase
  endfunction

  logic [10:0]            h_q, h_d, v_q, v_d;
  logic [9:0]             shx_q [NUM_SPRITES];
  logic [9:0]             shy_q [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] shen_q;
  logic                   vblank_q;
  logic                   latch;

  logic [NUM_SPRITES-1:0] hit_s0;
  logic [CW-1:0]          col_s0 [NUM_SPRITES];
  logic [CW-1:0]          row_s0 [NUM_SPRITES];
  logic                   act_s0, grid_s0, hs_s0, vs_s0;

  logic [ROWW-1:0]        ram_q [NUM_SPRITES][SPRITE_SIZE];
  logic [8:0]             pal_q [NPAL];

  logic [NUM_SPRITES-1:0] hit1_q;
  logic [CW-1:0]          col1_q [NUM_SPRITES];
  logic [ROWW-1:0]        dat1_q [NUM_SPRITES];
  logic                   act1_q, grid1_q, hs1_q, vs1_q;

  logic                   win;
  logic [BPP-1:0]         widx, pix;
  logic [8:0]             rgb_d, rgb_q;
  logic                   hs2_q, vs2_q;

  always_comb begin
    h_d = h_q + 11'd1;
    v_d = v_q;
    if (h_q == 11'(H_TOTAL - 1)) begin
      h_d = '0;
      v_d = (v_q == 11'(V_TOTAL - 1)) ? '0 : v_q + 11'd1;
    end
  end

  assign latch = (h_q == 11'd0) && (v_q == 11'(V_DISPLAY));

  // Hit test at 11 bits so x+SPRITE_SIZE never wraps back onto the left edge.
  always_comb begin
    hit_s0 = '0;
    col_s0 = '{default: '0};
    row_s0 = '{default: '0};
    for (int unsigned s = 0; s < NUM_SPRITES; s++) begin
      hit_s0[s] = shen_q[s]
                && (h_q >= {1'b0, shx_q[s]}) && (h_q < {1'b0, shx_q[s]} + 11'(SPRITE_SIZE))
                && (v_q >= {1'b0, shy_q[s]}) && (v_q < {1'b0, shy_q[s]} + 11'(SPRITE_SIZE));
      col_s0[s] = CW'(h_q - {1'b0, shx_q[s]});
      row_s0[s] = CW'(v_q - {1'b0, shy_q[s]});
    end
    act_s0  = (h_q < 11'(H_DISPLAY)) && (v_q < 11'(V_DISPLAY));
    grid_s0 = ((h_q & GMASK) == '0) || ((v_q & GMASK) == '0);
    hs_s0   = (h_q >= 11'(H_DISPLAY + H_FRONT)) && (h_q < 11'(H_DISPLAY + H_FRONT + H_SYNC));
    vs_s0   = (v_q >= 11'(V_DISPLAY + V_FRONT)) && (v_q < 11'(V_DISPLAY + V_FRONT + V_SYNC));
  end

  always_ff @(posedge clk) begin
    if (wr_en && (32'(wr_sel) < NUM_SPRITES)) begin
      ram_q[wr_sel][wr_row] <= wr_data;
    end
  end

  always_comb begin
    win  = 1'b0;
    widx = '0;
    pix  = '0;
    for (int unsigned s = 0; s < NUM_SPRITES; s++) begin
      pix = dat1_q[s][col1_q[s]*BPP +: BPP];
      if (!win && hit1_q[s] && (pix != '0)) begin
        win  = 1'b1;
        widx = pix;
      end
    end
    rgb_d = '0;
    if (act1_q) begin
      if (win) begin
        rgb_d = pal_q[widx];
      end else if ((GRID_EN != 0) && grid1_q) begin
        rgb_d = '1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q      <= '0;
      v_q      <= '0;
      shx_q    <= '{default: '0};
      shy_q    <= '{default: '0};
      shen_q   <= '0;
      vblank_q <= 1'b0;
      hit1_q   <= '0;
      col1_q   <= '{default: '0};
      dat1_q   <= '{default: '0};
      act1_q   <= 1'b0;
      grid1_q  <= 1'b0;
      hs1_q    <= 1'b0;
      vs1_q    <= 1'b0;
      rgb_q    <= '0;
      hs2_q    <= 1'b0;
      vs2_q    <= 1'b0;
      for (int unsigned i = 0; i < NPAL; i++) begin
        pal_q[i] <= pal_init(i);
      end
    end else begin
      h_q      <= h_d;
      v_q      <= v_d;
      vblank_q <= latch;
      if (latch) begin
        for (int unsigned s = 0; s < NUM_SPRITES; s++) begin
          shx_q[s] <= sprite_x[s*10 +: 10];
          shy_q[s] <= sprite_y[s*10 +: 10];
        end
        shen_q <= sprite_en;
      end
      hit1_q <= hit_s0;
      col1_q <= col_s0;
      for (int unsigned s = 0; s < NUM_SPRITES; s++) begin
        dat1_q[s] <= ram_q[s][row_s0[s]];
      end
      act1_q  <= act_s0;
      grid1_q <= grid_s0;
      hs1_q   <= hs_s0;
      vs1_q   <= vs_s0;
      rgb_q   <= rgb_d;
      hs2_q   <= hs1_q;
      vs2_q   <= vs1_q;
      if (pal_wr) begin
        pal_q[pal_idx] <= pal_data;
      end
    end
  end

  assign red          = rgb_q[8:6];
  assign green        = rgb_q[5:3];
  assign blue         = rgb_q[2:0];
  assign hsync        = hs2_q;
  assign vsync        = vs2_q;
  assign vblank_start = vblank_q;
endmodule
